// File: rtl/multi_issue_dmem_arbiter_pkg.sv
// dmem_arb_pkg: shared constants and width helpers for the multi-issue DMEM
// arbiter. No ports; the defaults below follow the build-wide core count and
// DMEM address width when those macros are defined.
`ifndef NCORES
`define NCORES 4
`endif
`ifndef DMEM_ADDRW
`define DMEM_ADDRW 16
`endif

package dmem_arb_pkg;

  localparam int DEF_NCORES     = `NCORES;
  localparam int DEF_ADDR_WIDTH = `DMEM_ADDRW;

  // Same-word comparisons ignore the byte offset within a 32-bit word.
  localparam int WORD_LSB = 2;

  // Selector width; a single requester still needs a 1-bit selector.
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of a counter that must be able to hold the value 'limit'.
  function automatic int starve_cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/multi_issue_dmem_arbiter_rr_find_first.sv
// rr_find_first: combinational rotate-and-find-first.
// Ports:
//   mask   in  N     candidate set
//   ptr    in  SELW  starting index of the search
//   onehot out N     first set bit of mask at or after ptr (wrapping)
//   idx    out SELW  index of that bit
//   found  out 1     mask has at least one bit set
module rr_find_first #(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic [N-1:0]    mask,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    onehot,
  output logic [SELW-1:0] idx,
  output logic            found
);

  logic [N-1:0] rot;
  logic [N-1:0] iso;

  always_comb begin
    // Shifting the doubled mask right by ptr puts core ptr at bit 0.
    rot = N'({mask, mask} >> ptr);
    // Isolate the lowest set bit.
    iso = rot & ~(rot - N'(1));
    // Shift the doubled result back left; the upper half is de-rotated.
    onehot = N'({iso, iso} << ptr >> N);
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) idx = idx | SELW'(i);
    end
    found = |mask;
  end

endmodule

// File: rtl/multi_issue_dmem_arbiter.sv
// multi_issue_dmem_arbiter: registered round-robin arbiter granting up to
// NPORTS of NCORES LSU requests per cycle onto a multi-ported DMEM, with a
// same-word conflict filter, grant locking until accept and starvation boost.
// Ports:
//   clk_i              in  1                  clock
//   rst_i              in  1                  synchronous reset, active-high
//   req_valid_i        in  NCORES             per-core request
//   req_addr_packed_i  in  NCORES*ADDR_WIDTH  core i byte address at slice i
//   port_ready_i       in  NPORTS             port p accepts this cycle
//   port_valid_o       out NPORTS             port p carries a grant
//   port_sel_o         out NPORTS*SELW        core index driven on port p
//   gnt_o              out NCORES             core i accepted this cycle
//   rr_ptr_o           out SELW               current round-robin pointer
module multi_issue_dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NCORES       = DEF_NCORES,
  parameter int NPORTS       = 2,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int STARVE_LIMIT = 8,
  parameter int SELW         = sel_width(NCORES)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NCORES-1:0]            req_valid_i,
  input  logic [NCORES*ADDR_WIDTH-1:0] req_addr_packed_i,
  input  logic [NPORTS-1:0]            port_ready_i,
  output logic [NPORTS-1:0]            port_valid_o,
  output logic [NPORTS*SELW-1:0]       port_sel_o,
  output logic [NCORES-1:0]            gnt_o,
  output logic [SELW-1:0]              rr_ptr_o
);

  localparam int CNTW  = starve_cnt_width(STARVE_LIMIT);
  localparam int WORDW = ADDR_WIDTH - WORD_LSB;
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(STARVE_LIMIT);

  logic [SELW-1:0]   rr_ptr;
  logic [NPORTS-1:0] lock_valid;
  logic [SELW-1:0]   lock_sel [NPORTS];
  logic [CNTW-1:0]   wait_cnt [NCORES];

  logic [WORDW-1:0]        core_word [NCORES];
  logic [NCORES*WORD_LSB-1:0] byte_bits;
  logic [NCORES-1:0]       locked_mask;
  logic [NPORTS*WORDW-1:0] lock_word;
  logic [NPORTS-1:0]       free_valid;
  logic [SELW-1:0]         free_sel [NPORTS];
  logic [SELW-1:0]         rr_next;

  function automatic int rot_core(input int base, input int k);
    int c;
    c = base + k;
    if (c >= NCORES) c = c - NCORES;
    return c;
  endfunction

  always_comb begin
    for (int i = 0; i < NCORES; i++) begin
      core_word[i] = req_addr_packed_i[i*ADDR_WIDTH + WORD_LSB +: WORDW];
      byte_bits[i*WORD_LSB +: WORD_LSB] = req_addr_packed_i[i*ADDR_WIDTH +: WORD_LSB];
    end
  end

  // Locked ports are claimed before any free search and take part in the
  // same-word filter regardless of their port number.
  always_comb begin
    locked_mask = '0;
    for (int p = 0; p < NPORTS; p++) begin
      lock_word[p*WORDW +: WORDW] = core_word[lock_sel[p]];
      if (lock_valid[p]) locked_mask[lock_sel[p]] = 1'b1;
    end
  end

  // Free ports search in ascending order; each port passes the set of used
  // cores and claimed words to the next, and each try inside a port masks
  // the previously rejected candidate.
  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    logic [NCORES-1:0]       used_in, used_out, avail;
    logic [NPORTS-1:0]       taken_vld_in, taken_vld_out;
    logic [NPORTS*WORDW-1:0] taken_word_in, taken_word_out;
    logic                    hit;
    logic [SELW-1:0]         hit_sel;
    logic [NCORES-1:0]       hit_oh;

    if (p == 0) begin : g_head
      assign used_in       = locked_mask;
      assign taken_vld_in  = lock_valid;
      assign taken_word_in = lock_word;
    end else begin : g_link
      assign used_in       = g_port[p-1].used_out;
      assign taken_vld_in  = g_port[p-1].taken_vld_out;
      assign taken_word_in = g_port[p-1].taken_word_out;
    end

    assign avail = lock_valid[p] ? '0 : (req_valid_i & ~used_in);

    for (genvar t = 0; t < NCORES; t++) begin : g_try
      logic [NCORES-1:0] mask_in, onehot, oh_in, oh_out;
      logic [SELW-1:0]   idx, sel_in, sel_out;
      logic              found, conflict, ok, hit_in, hit_out;

      if (t == 0) begin : g_t0
        assign mask_in = avail;
        assign hit_in  = 1'b0;
        assign sel_in  = '0;
        assign oh_in   = '0;
      end else begin : g_tn
        // Once a try succeeds the remaining tries see an empty mask.
        assign mask_in = g_try[t-1].ok ? '0
                       : (g_try[t-1].mask_in & ~g_try[t-1].onehot);
        assign hit_in  = g_try[t-1].hit_out;
        assign sel_in  = g_try[t-1].sel_out;
        assign oh_in   = g_try[t-1].oh_out;
      end

      rr_find_first #(.N(NCORES), .SELW(SELW)) u_find (
        .mask   (mask_in),
        .ptr    (rr_ptr),
        .onehot (onehot),
        .idx    (idx),
        .found  (found)
      );

      always_comb begin
        conflict = 1'b0;
        for (int q = 0; q < NPORTS; q++) begin
          if (taken_vld_in[q] && (taken_word_in[q*WORDW +: WORDW] == core_word[idx]))
            conflict = 1'b1;
        end
      end

      assign ok      = found & ~conflict;
      assign hit_out = hit_in | ok;
      assign sel_out = ok ? idx : sel_in;
      assign oh_out  = ok ? onehot : oh_in;
    end

    assign hit     = g_try[NCORES-1].hit_out;
    assign hit_sel = g_try[NCORES-1].sel_out;
    assign hit_oh  = g_try[NCORES-1].oh_out;

    assign free_valid[p] = hit;
    assign free_sel[p]   = hit_sel;
    assign used_out      = used_in | hit_oh;
    assign taken_vld_out = taken_vld_in | (NPORTS'(hit) << p);

    always_comb begin
      taken_word_out = taken_word_in;
      if (hit) taken_word_out[p*WORDW +: WORDW] = core_word[hit_sel];
    end
  end

  // Only the last port's chain outputs and the byte offsets go nowhere.
  logic unused_tail;
  assign unused_tail = ^{byte_bits, g_port[NPORTS-1].used_out,
                         g_port[NPORTS-1].taken_vld_out,
                         g_port[NPORTS-1].taken_word_out};

  always_comb begin
    port_valid_o = '0;
    port_sel_o   = '0;
    gnt_o        = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (!rst_i) begin
        if (lock_valid[p]) begin
          port_valid_o[p]                = 1'b1;
          port_sel_o[p*SELW +: SELW]     = lock_sel[p];
        end else if (free_valid[p]) begin
          port_valid_o[p]                = 1'b1;
          port_sel_o[p*SELW +: SELW]     = free_sel[p];
        end
      end
    end
    for (int p = 0; p < NPORTS; p++) begin
      if (port_valid_o[p] && port_ready_i[p])
        gnt_o[port_sel_o[p*SELW +: SELW]] = 1'b1;
    end
  end

  // Pointer moves past the last accepted core in rotated order; a saturated
  // starvation counter overrides that and points at the lowest starved core.
  always_comb begin
    int c;
    rr_next = rr_ptr;
    for (int k = 0; k < NCORES; k++) begin
      c = rot_core(int'(rr_ptr), k);
      if (gnt_o[c]) rr_next = (c == NCORES - 1) ? '0 : SELW'(c + 1);
    end
    for (int i = NCORES - 1; i >= 0; i--) begin
      if (wait_cnt[i] == CNT_MAX) rr_next = SELW'(i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr     <= '0;
      lock_valid <= '0;
      for (int p = 0; p < NPORTS; p++) lock_sel[p] <= '0;
      for (int i = 0; i < NCORES; i++) wait_cnt[i] <= '0;
    end else begin
      rr_ptr <= rr_next;
      for (int p = 0; p < NPORTS; p++) begin
        lock_valid[p] <= port_valid_o[p] & ~port_ready_i[p];
        lock_sel[p]   <= port_sel_o[p*SELW +: SELW];
      end
      for (int i = 0; i < NCORES; i++) begin
        if (req_valid_i[i] && !gnt_o[i]) begin
          if (wait_cnt[i] != CNT_MAX) wait_cnt[i] <= wait_cnt[i] + CNTW'(1);
        end else begin
          wait_cnt[i] <= '0;
        end
      end
    end
  end

  assign rr_ptr_o = rr_ptr;

endmodule

// File: tb/tb_multi_issue_dmem_arbiter.sv
// Scoreboard bench for multi_issue_dmem_arbiter (4 cores, 2 ports, 16-bit
// addresses, starvation limit 2). Each stimulus cycle pushes its hand-derived
// expected outputs; a monitor pops and compares on the falling edge.
module tb_multi_issue_dmem_arbiter;

  localparam int NC = 4;
  localparam int NP = 2;
  localparam int AW = 16;
  localparam int SL = 2;
  localparam int SW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NC-1:0]    req_valid;
  logic [NC*AW-1:0] req_addr;
  logic [NP-1:0]    port_ready;
  logic [NP-1:0]    port_valid;
  logic [NP*SW-1:0] port_sel;
  logic [NC-1:0]    gnt;
  logic [SW-1:0]    rr_ptr;

  always #5 clk = ~clk;

  multi_issue_dmem_arbiter #(
    .NCORES(NC), .NPORTS(NP), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .req_valid_i       (req_valid),
    .req_addr_packed_i (req_addr),
    .port_ready_i      (port_ready),
    .port_valid_o      (port_valid),
    .port_sel_o        (port_sel),
    .gnt_o             (gnt),
    .rr_ptr_o          (rr_ptr)
  );

  typedef struct {
    int         cyc;
    logic [1:0] pv;
    logic [1:0] s0;
    logic [1:0] s1;
    logic [3:0] g;
    logic [1:0] ptr;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  localparam logic [15:0] A0 = 16'h0000, A1 = 16'h0010, A2 = 16'h0020, A3 = 16'h0030;

  task automatic step(input logic r, input logic [3:0] v,
                      input logic [15:0] a0, input logic [15:0] a1,
                      input logic [15:0] a2, input logic [15:0] a3,
                      input logic [1:0] rdy, input logic [1:0] pv,
                      input logic [1:0] s0, input logic [1:0] s1,
                      input logic [3:0] g, input logic [1:0] ptr);
    exp_t e;
    @(posedge clk);
    #1;
    rst        = r;
    req_valid  = v;
    req_addr   = {a3, a2, a1, a0};
    port_ready = rdy;
    e.cyc = cyc; e.pv = pv; e.s0 = s0; e.s1 = s1; e.g = g; e.ptr = ptr;
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic cmp(input string nm, input int c, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL cyc%0d %s got=%0h want=%0h", c, nm, got, want);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("port_valid", e.cyc, 8'(port_valid),    8'(e.pv));
        cmp("port_sel0",  e.cyc, 8'(port_sel[1:0]), 8'(e.s0));
        cmp("port_sel1",  e.cyc, 8'(port_sel[3:2]), 8'(e.s1));
        cmp("gnt",        e.cyc, 8'(gnt),           8'(e.g));
        cmp("rr_ptr",     e.cyc, 8'(rr_ptr),        8'(e.ptr));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Stimulus: r, valid, a0..a3, ready | expected pv, sel0, sel1, gnt, rr_ptr
  initial begin
    rst = 1'b1; req_valid = '0; req_addr = '0; port_ready = '0;
    // reset gates outputs even with requests present
    step(1, 4'b1111, A0, A1, A2, A3, 2'b11, 2'b00, 0, 0, 4'b0000, 0);
    step(1, 4'b1111, A0, A1, A2, A3, 2'b11, 2'b00, 0, 0, 4'b0000, 0);
    // round-robin over distinct words
    step(0, 4'b1111, A0, A1, A2, A3, 2'b11, 2'b11, 0, 1, 4'b0011, 0);
    step(0, 4'b1111, A0, A1, A2, A3, 2'b11, 2'b11, 2, 3, 4'b1100, 2);
    step(0, 4'b0000, A0, A1, A2, A3, 2'b11, 2'b00, 0, 0, 4'b0000, 0);
    // same-word conflict: cores 1 and 2 share word 0x40
    step(0, 4'b0001, A0, A1, A2, A3, 2'b11, 2'b01, 0, 0, 4'b0001, 0);
    step(0, 4'b1110, A0, 16'h0040, 16'h0042, 16'h0080, 2'b11, 2'b11, 1, 3, 4'b1010, 1);
    step(0, 4'b0100, A0, A1, 16'h0042, A3, 2'b11, 2'b01, 2, 0, 4'b0100, 0);
    step(0, 4'b0000, A0, A1, A2, A3, 2'b11, 2'b00, 0, 0, 4'b0000, 3);
    // port0 stalls on core 0; port1 keeps rotating without core 0
    step(0, 4'b0001, A0, A1, A2, A3, 2'b10, 2'b01, 0, 0, 4'b0000, 3);
    step(0, 4'b1111, A0, A1, A2, A3, 2'b10, 2'b11, 0, 3, 4'b1000, 3);
    step(0, 4'b1111, A0, A1, A2, A3, 2'b10, 2'b11, 0, 1, 4'b0010, 0);
    step(0, 4'b1111, A0, A1, A2, A3, 2'b11, 2'b11, 0, 1, 4'b0011, 0);
    step(0, 4'b0000, A0, A1, A2, A3, 2'b11, 2'b00, 0, 0, 4'b0000, 0);
    step(0, 4'b0000, A0, A1, A2, A3, 2'b11, 2'b00, 0, 0, 4'b0000, 2);
    // core 3 shares a word with core 2 and starves until boosted
    step(0, 4'b1110, A0, A1, 16'h0080, 16'h0080, 2'b11, 2'b11, 2, 1, 4'b0110, 2);
    step(0, 4'b1110, A0, A1, 16'h0080, 16'h0080, 2'b11, 2'b11, 2, 1, 4'b0110, 2);
    step(0, 4'b1110, A0, A1, 16'h0080, 16'h0080, 2'b11, 2'b11, 2, 1, 4'b0110, 2);
    step(0, 4'b1110, A0, A1, 16'h0080, 16'h0080, 2'b11, 2'b11, 3, 1, 4'b1010, 3);
    step(0, 4'b0000, A0, A1, A2, A3, 2'b11, 2'b00, 0, 0, 4'b0000, 3);
    // reset while port0 is locked on core 1
    step(0, 4'b0010, A0, A1, A2, A3, 2'b00, 2'b01, 1, 0, 4'b0000, 3);
    step(1, 4'b0010, A0, A1, A2, A3, 2'b00, 2'b00, 0, 0, 4'b0000, 3);
    step(0, 4'b0100, A0, A1, A2, A3, 2'b11, 2'b01, 2, 0, 4'b0100, 0);
    // lone requester at the top core: pointer wraps every accept
    step(0, 4'b1000, A0, A1, A2, A3, 2'b11, 2'b01, 3, 0, 4'b1000, 3);
    step(0, 4'b1000, A0, A1, A2, A3, 2'b11, 2'b01, 3, 0, 4'b1000, 0);
    step(0, 4'b1000, A0, A1, A2, A3, 2'b11, 2'b01, 3, 0, 4'b1000, 0);
    // both ports locked: no new grants, starvation still counts
    step(0, 4'b0011, A0, A1, A2, A3, 2'b00, 2'b11, 0, 1, 4'b0000, 0);
    step(0, 4'b0111, A0, A1, A2, A3, 2'b00, 2'b11, 0, 1, 4'b0000, 0);
    step(0, 4'b0111, A0, A1, A2, A3, 2'b11, 2'b11, 0, 1, 4'b0011, 0);
    step(0, 4'b0100, A0, A1, A2, A3, 2'b11, 2'b01, 2, 0, 4'b0100, 0);
    step(0, 4'b0000, A0, A1, A2, A3, 2'b11, 2'b00, 0, 0, 4'b0000, 2);

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_issue_dmem_arbiter.md
Name: multi_issue_dmem_arbiter

Overview:
- Registered, parametrised successor to the combinational single/dual-issue DMEM arbiters.
- Grants up to NPORTS of NCORES core requests per cycle onto NPORTS data-memory ports.
- Grant order is round-robin from a stored pointer, with a same-word conflict filter.
- Holds a grant on a port until that port accepts it, and forces priority to any core starved for STARVE_LIMIT cycles.
- Sits between core LSU request lines and the multi-ported DMEM.

Parameters:
- NCORES, `NCORES: number of requesters; must be >= 2.
- NPORTS, 2: memory ports, i.e. grants per cycle; 1 <= NPORTS <= NCORES.
- ADDR_WIDTH, `DMEM_ADDRW: byte address width.
- STARVE_LIMIT, 8: consecutive denied cycles before forced priority; >= 1.
- SELW, $clog2(NCORES): selector width (derived).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- req_valid_i  in  NCORES  per-core request.
- req_addr_packed_i  in  NCORES*ADDR_WIDTH  core i occupies bits [ADDR_WIDTH*(i+1)-1 : ADDR_WIDTH*i].
- port_ready_i  in  NPORTS  port p accepts this cycle.
- port_valid_o  out  NPORTS  port p carries a grant.
- port_sel_o  out  NPORTS*SELW  core index for port p, packed like the addresses.
- gnt_o  out  NCORES  one-hot-per-core accept: port_valid & port_ready & sel==i.
- rr_ptr_o  out  SELW  current round-robin pointer.

Behaviour:
- Handshake: a transfer completes on port p when port_valid_o[p] & port_ready_i[p]. A granted core keeps req_valid_i and its address stable until its gnt_o bit is seen.
- State registers: rr_ptr (SELW), lock_valid[NPORTS], lock_sel[NPORTS], wait_cnt[NCORES] (width $clog2(STARVE_LIMIT+1)).
- Reset (rst_i high at a clock edge):
  - rr_ptr=0, lock_valid=0, wait_cnt=0.
  - While rst_i is high, port_valid_o=0 and gnt_o=0; port_sel_o=0 and rr_ptr_o=0 from the following cycle.
  - Reset mid-transfer drops all locks; no grant survives reset.
- Locked ports:
  - If lock_valid[p]: port_valid_o[p]=1, port_sel_o[p]=lock_sel[p].
  - Locked cores are removed from the free candidate set.
- Free ports, in ascending p:
  - Take the next candidate by rotate-and-find-first starting at rr_ptr, with already-chosen cores masked out.
  - The candidate is granted only if addr[ADDR_WIDTH-1:2] differs from every port already granted this cycle, locked ports included.
  - A conflicting candidate is skipped; search continues with the next core. At most NCORES candidates are examined per port.
  - Nothing found: port_valid_o[p]=0 and port_sel_o[p]=0.
- Combinational latency: request to port_valid_o is 0 cycles. Outputs depend only on registered state and current inputs; there is no path from port_ready_i to port_valid_o.
- Lock update: lock_valid[p] <= port_valid_o[p] & ~port_ready_i[p]; lock_sel[p] <= port_sel_o[p].
- Pointer update, when any gnt_o bit is set:
  - rr_ptr <= (highest-numbered accepted core index in rotated order) + 1, mod NCORES, wrapping NCORES-1 to 0.
  - Otherwise rr_ptr holds.
- Starvation:
  - wait_cnt[i] increments, saturating at STARVE_LIMIT, when req_valid_i[i] & ~gnt_o[i].
  - It clears on gnt_o[i] or ~req_valid_i[i].
  - If any wait_cnt equals STARVE_LIMIT, next cycle rr_ptr <= lowest such i. This overrides the normal pointer update.
- Simultaneous events:
  - Acceptance and a new request on the same port in the same cycle: the new grant appears next cycle.
  - All ports locked: no new grants are issued; counters keep running.

Decomposition:
- Package dmem_arb_pkg: SELW function (NCORES==1 guard), word-address extraction constant (bit 2 base), STARVE counter width function.
- Sub-module rr_find_first: inputs mask[NCORES], ptr[SELW]; outputs onehot[NCORES], idx[SELW], found. It uses the double-width rotate, x & ~(x-1), de-rotate and OR-fold technique. Instantiate it per port; conflict skipping masks the rejected index and re-invokes it, unrolled to NCORES tries per port.

Test Plan:
- NCORES=4, NPORTS=2, all ready=1, all cores requesting distinct words, rr_ptr=0 -> cycle0 ports grant cores 0,1 and rr_ptr becomes 2; cycle1 grants 2,3 and rr_ptr becomes 0.
- Cores 1 and 2 request the same word 0x40, ptr=1, core 3 requests 0x80 -> port0=1, port1=3; core 2 is denied and wait_cnt[2] becomes 1.
- port_ready_i[0]=0 for 3 cycles while core 0 is granted -> port0 keeps sel=0 for all 3 cycles; other cores rotate on port1; core 0 is never chosen for port1.
- STARVE_LIMIT=2, core 3 always conflicting with a higher-priority core -> after 2 denied cycles rr_ptr=3 and core 3 is granted on port0.
- Assert rst_i mid-lock -> port_valid_o=0 and gnt_o=0 immediately; next cycle rr_ptr=0 and no lock remains.
- NPORTS=1 with a single requester at core NCORES-1 -> granted every cycle; rr_ptr wraps to 0 on each accept.
